// File: rtl/uart_receiver.sv
// UART receiver: 6-9 data bits, optional parity, 1/2 stop bits, break detect.
// Define UART_RX_SILENCE_EN to build the idle-line (silence) detector.
module uart_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic [1:0]  dataBits_i,
  input  logic        hasParity_i,
  input  logic [1:0]  parityMode_i,
  input  logic        extraStopBit_i,
  input  logic [23:0] clockDivisor_i,
  input  logic        receiveReq_i,
  output logic [8:0]  dataOut_o,
  output logic        dataReceived_o,
  output logic        parityError_o,
  output logic        overflow_o,
  output logic        break_o,
  output logic        silence_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAKWAIT
  } state_t;

  state_t      state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] div_q, div_d;
  logic [3:0]  nbits_q, nbits_d;
  logic        par_en_q, par_en_d;
  logic [1:0]  par_mode_q, par_mode_d;
  logic        two_stop_q, two_stop_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [8:0]  shreg_q, shreg_d;
  logic        par_bit_q, par_bit_d;
  logic        done_q, done_d;
  logic        break_q, break_d;
  logic [8:0]  dout_q, dout_d;
  logic        drx_q, drx_d;
  logic        perr_q, perr_d;
  logic        ovf_q, ovf_d;

  logic [23:0] div_eff;
  logic        tick;
  logic        par_exp;
  logic        perr_new;

  assign div_eff = (clockDivisor_i < 24'd4) ? 24'd4 : clockDivisor_i;
  assign tick    = (cnt_q == 24'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
    break_d    = break_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d    = S_START;
          cnt_d      = div_eff >> 1;
          div_d      = div_eff;
          nbits_d    = {2'b00, dataBits_i} + 4'd6;
          par_en_d   = hasParity_i;
          par_mode_d = parityMode_i;
          two_stop_d = extraStopBit_i;
          bit_idx_d  = 4'd0;
          stop_idx_d = 1'b0;
          shreg_d    = 9'd0;
          par_bit_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = div_q;
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d              = div_q;
          shreg_d[bit_idx_q] = rx_s2_q;
          bit_idx_d          = bit_idx_q + 4'd1;
          if (bit_idx_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d     = div_q;
          par_bit_d = rx_s2_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = div_q;
          if (!rx_s2_q) begin
            // an all-zero frame with a low stop bit is a line break
            state_d = S_BREAKWAIT;
            if (shreg_q == 9'd0 && !par_bit_q) begin
              break_d = 1'b1;
            end
          end else if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_BREAKWAIT: begin
        if (rx_s2_q) begin
          state_d = S_IDLE;
          break_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (par_mode_q)
      2'd0:    par_exp = ^shreg_q;
      2'd1:    par_exp = ~^shreg_q;
      2'd2:    par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  assign perr_new = par_en_q && (par_bit_q != par_exp);

  // a completion coinciding with receiveReq is accepted, not an overflow
  always_comb begin
    dout_d = dout_q;
    perr_d = perr_q;
    drx_d  = drx_q;
    ovf_d  = ovf_q;
    if (receiveReq_i) begin
      drx_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (done_q) begin
      if (!drx_q || receiveReq_i) begin
        dout_d = shreg_q;
        perr_d = perr_new;
        drx_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= 24'd0;
      div_q      <= 24'd4;
      nbits_q    <= 4'd6;
      par_en_q   <= 1'b0;
      par_mode_q <= 2'd0;
      two_stop_q <= 1'b0;
      bit_idx_q  <= 4'd0;
      stop_idx_q <= 1'b0;
      shreg_q    <= 9'd0;
      par_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      break_q    <= 1'b0;
      dout_q     <= 9'd0;
      drx_q      <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      done_q     <= done_d;
      break_q    <= break_d;
      dout_q     <= dout_d;
      drx_q      <= drx_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dataOut_o      = dout_q;
  assign dataReceived_o = drx_q;
  assign parityError_o  = perr_q;
  assign overflow_o     = ovf_q;
  assign break_o        = break_q;

`ifdef UART_RX_SILENCE_EN
  logic [27:0] idle_q, idle_d;
  logic [27:0] idle_lim;

  assign idle_lim = 28'(div_eff) * 28'd10;

  always_comb begin
    idle_d = idle_q;
    if (!rx_s2_q) begin
      idle_d = 28'd0;
    end else if (idle_q < idle_lim) begin
      idle_d = idle_q + 28'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= 28'd0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign silence_o = (idle_q >= idle_lim);
`else
  assign silence_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: vector table of frames plus
// hand-written sequences for break, overflow, glitch, reset and silence.
module tb_uart_receiver;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [1:0]  dbits;
  logic        has_par;
  logic [1:0]  pmode;
  logic        two_stop;
  logic [23:0] div;
  logic        req;
  logic [8:0]  dout;
  logic        drx;
  logic        perr;
  logic        ovf;
  logic        brk;
  logic        sil;

  int n_cmp;
  int n_bad;

  uart_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .rx_i           (rx),
    .dataBits_i     (dbits),
    .hasParity_i    (has_par),
    .parityMode_i   (pmode),
    .extraStopBit_i (two_stop),
    .clockDivisor_i (div),
    .receiveReq_i   (req),
    .dataOut_o      (dout),
    .dataReceived_o (drx),
    .parityError_o  (perr),
    .overflow_o     (ovf),
    .break_o        (brk),
    .silence_o      (sil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dbits;
    logic        par;
    logic [1:0]  pmode;
    logic        two;
    logic [23:0] div;
    int          bl;
    logic [8:0]  word;
    logic        pbit;
    logic [8:0]  exp_data;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] b, input logic p,
                     input logic [1:0] m, input logic t,
                     input logic [23:0] d);
    dbits    = b;
    has_par  = p;
    pmode    = m;
    two_stop = t;
    div      = d;
  endtask

  task automatic send_frame(input logic [8:0] w, input int nb,
                            input logic pen, input logic pbit,
                            input logic two, input logic s1,
                            input logic s2, input int bl);
    rx = 1'b0;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = w[i];
      repeat (bl) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (bl) @(negedge clk);
    end
    rx = s1;
    repeat (bl) @(negedge clk);
    if (two) begin
      rx = s2;
      repeat (bl) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * bl + 4) @(negedge clk);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    rx    = 1'b1;
    req   = 1'b0;
    cfg(2'd2, 1'b0, 2'd0, 1'b0, 24'd10);

    vecs[0] = '{2'd2, 1'b0, 2'd0, 1'b0, 24'd10, 10, 9'h055, 1'b0, 9'h055, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 2'd0, 1'b0, 24'd10, 10, 9'h0A5, 1'b1, 9'h0A5, 1'b1};
    vecs[2] = '{2'd2, 1'b1, 2'd0, 1'b0, 24'd10, 10, 9'h0A5, 1'b0, 9'h0A5, 1'b0};
    vecs[3] = '{2'd1, 1'b1, 2'd1, 1'b0, 24'd10, 10, 9'h041, 1'b1, 9'h041, 1'b0};
    vecs[4] = '{2'd3, 1'b1, 2'd1, 1'b0, 24'd10, 10, 9'h1FF, 1'b1, 9'h1FF, 1'b1};
    vecs[5] = '{2'd0, 1'b1, 2'd2, 1'b0, 24'd10, 10, 9'h02A, 1'b0, 9'h02A, 1'b1};
    vecs[6] = '{2'd0, 1'b1, 2'd3, 1'b0, 24'd10, 10, 9'h1D5, 1'b0, 9'h015, 1'b0};
    vecs[7] = '{2'd2, 1'b0, 2'd0, 1'b1, 24'd16, 16, 9'h0C3, 1'b0, 9'h0C3, 1'b0};
    vecs[8] = '{2'd2, 1'b0, 2'd0, 1'b0, 24'd2,  4,  9'h096, 1'b0, 9'h096, 1'b0};
    vecs[9] = '{2'd3, 1'b1, 2'd0, 1'b0, 24'd7,  7,  9'h100, 1'b1, 9'h100, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 9'h000);
    chk("rst_drx", drx, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_brk", brk, 1'b0);
    chk("rst_sil", sil, 1'b0);
    rst = 1'b0;

    repeat (110) @(negedge clk);
`ifdef UART_RX_SILENCE_EN
    chk("sil_high", sil, 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("sil_fall", sil, 1'b0);
`else
    chk("sil_tied", sil, 1'b0);
    rx = 1'b0;
    repeat (3) @(negedge clk);
`endif
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("sil_glitch_drx", drx, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cfg(vecs[i].dbits, vecs[i].par, vecs[i].pmode, vecs[i].two,
          vecs[i].div);
      send_frame(vecs[i].word, int'(vecs[i].dbits) + 6, vecs[i].par,
                 vecs[i].pbit, vecs[i].two, 1'b1, 1'b1, vecs[i].bl);
      chk($sformatf("v%0d_drx", i), drx, 1'b1);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_data);
      chk($sformatf("v%0d_perr", i), perr, vecs[i].exp_perr);
      chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
      chk($sformatf("v%0d_brk", i), brk, 1'b0);
      pulse_req();
      chk($sformatf("v%0d_clr", i), drx, 1'b0);
    end

    cfg(2'd0, 1'b0, 2'd0, 1'b0, 24'd10);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (70) @(negedge clk);
    chk("raw_drx", drx, 1'b1);
    chk("raw_dout", dout, 9'h03C);
    chk("raw_perr", perr, 1'b0);
    chk("raw_brk", brk, 1'b0);
    pulse_req();

    cfg(2'd2, 1'b0, 2'd0, 1'b0, 24'd10);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_drx", drx, 1'b1);
    chk("ovf_dout", dout, 9'h011);
    pulse_req();
    chk("ovf_clr_drx", drx, 1'b0);
    chk("ovf_clr_ovf", ovf, 1'b0);

    rx = 1'b0;
    repeat (200) @(negedge clk);
    chk("brk_set", brk, 1'b1);
    chk("brk_drx", drx, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("brk_clr", brk, 1'b0);
    repeat (30) @(negedge clk);
    chk("brk_after_drx", drx, 1'b0);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_drx", drx, 1'b0);
    chk("glitch_brk", brk, 1'b0);
    chk("glitch_ovf", ovf, 1'b0);

    send_frame(9'h0AA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    send_frame(9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10);
    chk("stoplo_drx", drx, 1'b1);
    chk("stoplo_dout", dout, 9'h0AA);
    chk("stoplo_ovf", ovf, 1'b0);
    chk("stoplo_brk", brk, 1'b0);
    pulse_req();

    cfg(2'd2, 1'b0, 2'd0, 1'b1, 24'd10);
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10);
    chk("stop2lo_drx", drx, 1'b0);
    chk("stop2lo_brk", brk, 1'b0);

    cfg(2'd2, 1'b0, 2'd0, 1'b0, 24'd10);
    rx = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_drx", drx, 1'b0);
    chk("abort_dout", dout, 9'h000);
    send_frame(9'h0E7, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    chk("abort_next_drx", drx, 1'b1);
    chk("abort_next_dout", dout, 9'h0E7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have: rx  input  1  serial line, idle high; asynchronous to clk.
REQ-004 SHALL have: dataBits  input  2  data-bit count: 0=6, 1=7, 2=8, 3=9.
REQ-005 SHALL have: hasParity  input  1  1 = frame carries a parity bit after the data.
REQ-006 SHALL have: parityMode  input  2  0=even, 1=odd, 2=mark (always 1), 3=space (always 0).
REQ-007 SHALL have: extraStopBit  input  1  1 = two stop bits, 0 = one.
REQ-008 SHALL have: clockDivisor  input  24  clk cycles per bit; values below 4 behave as 4.
REQ-009 SHALL have: receiveReq  input  1  consume pulse from the host.
REQ-010 SHALL have: dataOut  output  9  last accepted word, LSB-first on the line, right-justified, unused upper bits 0.
REQ-011 SHALL have: dataReceived  output  1  level: unread word in dataOut.
REQ-012 SHALL have: parityError  output  1  parity mismatch on the word in dataOut.
REQ-013 SHALL have: overflow  output  1  sticky: a frame arrived while dataReceived was high.
REQ-014 SHALL have: break  output  1  line-break condition present.
REQ-015 SHALL have: silence  output  1  line idle for at least 10 bit times.

Function
REQ-016 SHALL synchronise rx through 2 flip-flops; all decisions use the synchronised value.
REQ-017 SHALL use states IDLE, START, DATA, PARITY, STOP, BREAKWAIT; the configuration inputs are sampled at the START entry and held for the whole frame.
REQ-018 IDLE: a synchronised falling edge SHALL enter START and load a bit counter with clockDivisor/2 (integer division).
REQ-019 START: at mid-bit, rx high SHALL return to IDLE (glitch rejection); rx low SHALL enter DATA.
REQ-020 DATA/PARITY/STOP: each bit SHALL be sampled once, exactly clockDivisor cycles after the previous sample.
REQ-021 PARITY SHALL be skipped when hasParity=0; STOP SHALL sample 1 or 2 stop bits per extraStopBit.
REQ-022 After the final stop sample with all stop bits high, SHALL return to IDLE and, on the next cycle, update dataOut/parityError and set dataReceived.
REQ-023 parityError SHALL be 1 iff hasParity=1 and the received parity bit differs from the expected bit (even: XOR of data; odd: its inverse; mark: 1; space: 0); otherwise 0.
REQ-024 If dataReceived=1 when a new frame completes, SHALL keep old dataOut/parityError, discard the new word, and set overflow.
REQ-025 receiveReq=1 SHALL clear dataReceived and overflow on the next edge; receiveReq in the same cycle as a completion SHALL accept the new word without setting overflow.
REQ-026 Any stop bit low with all data bits and the parity bit 0 SHALL assert break, discard the frame, and enter BREAKWAIT.
REQ-027 Any stop bit low otherwise SHALL discard the frame silently (no flag changes) and enter BREAKWAIT.
REQ-028 BREAKWAIT SHALL deassert break and go to IDLE once synchronised rx is high.
REQ-029 An idle counter SHALL reset on any synchronised rx low and count while rx is high; silence SHALL be 1 once the count reaches 10*clockDivisor cycles and 0 the cycle after rx falls.

Reset
REQ-030 On rst: state IDLE; dataOut=0, dataReceived=0, parityError=0, overflow=0, break=0, silence=0; idle counter and synchronisers cleared to idle (sync flops = 1).
REQ-031 rst asserted mid-frame SHALL abort the frame with no flag update.

Configuration
REQ-032 With macro UART_RX_SILENCE_EN defined, SHALL implement REQ-029.
REQ-033 Without UART_RX_SILENCE_EN, silence SHALL be tied to 0 and the idle counter SHALL be omitted.

Verification
REQ-034 divisor=10, dataBits=0, no parity, 1 stop, rx low for 30 cycles then high -> dataReceived=1, dataOut=9'h03C, parityError=0, break=0.
REQ-035 8 bits, even parity, byte 8'hA5 with wrong parity bit 1 -> dataReceived=1, dataOut=9'h0A5, parityError=1.
REQ-036 Two frames with no receiveReq -> overflow=1, dataOut holds the first word; then one receiveReq -> dataReceived=0, overflow=0.
REQ-037 rx low for 20 bit times -> break=1 and no dataReceived; break=0 within 3 cycles after rx returns high.
REQ-038 rx low pulse of 3 cycles, divisor 10 -> start rejected, no flag change.
REQ-039 UART_RX_SILENCE_EN defined, divisor 10, rx high 100 cycles after reset -> silence=1; rx falls -> silence=0 within 3 cycles.
